// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces a
// single-key press and release, and reports the key as a 4-bit scan code.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       press,
  output logic [3:0] scan_code,
  output logic       key_held
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_t;

  localparam logic [15:0] DIV_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DB_TARGET = 8'(DEBOUNCE_CNT);

  state_t      state;
  logic [3:0]  sync1;
  logic [3:0]  rs;
  logic [15:0] div_cnt;
  logic        tick;
  logic [7:0]  stab_cnt;
  logic [3:0]  cap_rs;
  logic [1:0]  r_idx;
  logic [1:0]  c_idx;

  function automatic logic one_low(input logic [3:0] v);
    logic [3:0] n;
    n = ~v;
    return (n != 4'h0) && ((n & (n - 4'd1)) == 4'h0);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] next_col(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // rows are asynchronous to clk; only the synchronized copy is ever decoded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 4'hF;
      rs    <= 4'hF;
    end else begin
      sync1 <= row;
      rs    <= sync1;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= 16'd0;
    end else if (tick) begin
      div_cnt <= 16'd0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SCAN;
      col       <= 4'b1110;
      press     <= 1'b0;
      scan_code <= 4'h0;
      key_held  <= 1'b0;
      stab_cnt  <= 8'd0;
      cap_rs    <= 4'hF;
      r_idx     <= 2'd0;
      c_idx     <= 2'd0;
    end else begin
      press <= 1'b0;
      case (state)
        SCAN: begin
          if (tick) begin
            if (one_low(rs)) begin
              cap_rs   <= rs;
              r_idx    <= low_index(rs);
              c_idx    <= low_index(col);
              stab_cnt <= 8'd1;
              state    <= DEBOUNCE;
            end else begin
              col <= next_col(col);
            end
          end
        end
        DEBOUNCE: begin
          if (tick) begin
            if (rs == cap_rs) begin
              if (sat_inc(stab_cnt) >= DB_TARGET) begin
                press     <= 1'b1;
                scan_code <= key_code(r_idx, c_idx);
                key_held  <= 1'b1;
                stab_cnt  <= 8'd0;
                state     <= EMIT;
              end else begin
                stab_cnt <= sat_inc(stab_cnt);
              end
            end else begin
              stab_cnt <= 8'd0;
              col      <= next_col(col);
              state    <= SCAN;
            end
          end
        end
        EMIT: begin
          state <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          // column stays frozen so the held key keeps pulling its row low
          if (tick) begin
            if (rs == 4'hF) begin
              if (sat_inc(stab_cnt) >= DB_TARGET) begin
                key_held <= 1'b0;
                stab_cnt <= 8'd0;
                col      <= next_col(col);
                state    <= SCAN;
              end else begin
                stab_cnt <= sat_inc(stab_cnt);
              end
            end else begin
              stab_cnt <= 8'd0;
            end
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3 and a
// behavioural 4x4 key matrix driving the row lines from the column drive.
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        press;
  logic [3:0]  scan_code;
  logic        key_held;
  logic [15:0] keys;
  logic        bounce;
  int          total;
  int          passed;
  int          press_cnt;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .press(press), .scan_code(scan_code), .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // key (r,c) pulls row r low while column c is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
    if (bounce) row = 4'hF;
  end

  always @(negedge clk) begin
    if (press) press_cnt = press_cnt + 1;
  end

  task automatic wait_col(input logic [3:0] v, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (col == v) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_press(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (press) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_released(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (!key_held) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; keys = 16'h0; bounce = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (col !== 4'b1110) $display("FAIL reset_col: got %b expected 1110", col); else passed++;
    total++; if (press !== 1'b0) $display("FAIL reset_press: got %b expected 0", press); else passed++;
    total++; if (scan_code !== 4'h0) $display("FAIL reset_code: got %h expected 0", scan_code); else passed++;
    total++; if (key_held !== 1'b0) $display("FAIL reset_held: got %b expected 0", key_held); else passed++;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_idle();
    logic [3:0] seq [4];
    int idx;
    int base;
    bit ok;
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;
    base = press_cnt;
    wait_col(4'b1101, 10, ok);
    total++; if (!ok) $display("FAIL idle_first_rotate: got col %b expected 1101 within 10 clocks", col); else passed++;
    idx = 1;
    for (int k = 0; k < 5; k++) begin
      repeat (3) @(posedge clk);
      #1;
      total++; if (col !== seq[idx]) $display("FAIL idle_hold%0d: got %b expected %b", k, col, seq[idx]); else passed++;
      @(posedge clk); #1;
      idx = (idx + 1) % 4;
      total++; if (col !== seq[idx]) $display("FAIL idle_step%0d: got %b expected %b", k, col, seq[idx]); else passed++;
    end
    total++; if (press_cnt !== base) $display("FAIL idle_no_press: got %0d presses expected 0", press_cnt - base); else passed++;
  endtask

  task automatic test_key5();
    int base;
    int n;
    bit ok;
    base = press_cnt;
    wait_col(4'b1110, 20, ok);
    keys = 16'h0; keys[5] = 1'b1;
    wait_col(4'b1101, 20, ok);
    total++; if (!ok) $display("FAIL key5_reach_col: got col %b expected 1101", col); else passed++;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      n++;
      if (press) break;
    end
    total++; if (n != 12) $display("FAIL key5_latency: got %0d clocks expected 12", n); else passed++;
    total++; if (scan_code !== 4'h5) $display("FAIL key5_code: got %h expected 5", scan_code); else passed++;
    total++; if (key_held !== 1'b1) $display("FAIL key5_held: got %b expected 1", key_held); else passed++;
    @(posedge clk); #1;
    total++; if (press !== 1'b0) $display("FAIL key5_width: got %b expected 0", press); else passed++;
    repeat (19) @(posedge clk);
    #1;
    total++; if (col !== 4'b1101) $display("FAIL key5_frozen: got %b expected 1101", col); else passed++;
    keys = 16'h0;
    repeat (11) @(posedge clk);
    #1;
    total++; if (key_held !== 1'b1) $display("FAIL key5_held_before_release: got %b expected 1", key_held); else passed++;
    @(posedge clk); #1;
    total++; if (key_held !== 1'b0) $display("FAIL key5_release: got %b expected 0", key_held); else passed++;
    total++; if (col !== 4'b1011) $display("FAIL key5_resume_col: got %b expected 1011", col); else passed++;
    total++; if (press_cnt - base != 1) $display("FAIL key5_pulses: got %0d expected 1", press_cnt - base); else passed++;
  endtask

  task automatic test_bounce();
    int base;
    bit ok;
    base = press_cnt;
    wait_col(4'b1110, 20, ok);
    keys = 16'h0; keys[13] = 1'b1;
    wait_col(4'b1101, 20, ok);
    repeat (5) @(posedge clk);
    #1; bounce = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (col !== 4'b1011) $display("FAIL bounce_col_advance: got %b expected 1011", col); else passed++;
    total++; if (press_cnt !== base) $display("FAIL bounce_no_press: got %0d presses expected 0", press_cnt - base); else passed++;
    total++; if (scan_code !== 4'h5) $display("FAIL bounce_code_kept: got %h expected 5", scan_code); else passed++;
    bounce = 1'b0;
    wait_press(100, ok);
    total++; if (!ok) $display("FAIL retry_press: got no press expected press within 100 clocks"); else passed++;
    total++; if (scan_code !== 4'h0) $display("FAIL retry_code: got %h expected 0", scan_code); else passed++;
    keys = 16'h0;
    wait_released(60, ok);
    total++; if (!ok) $display("FAIL retry_release: got key_held %b expected 0 within 60 clocks", key_held); else passed++;
    total++; if (press_cnt - base != 1) $display("FAIL retry_pulses: got %0d expected 1", press_cnt - base); else passed++;
  endtask

  task automatic test_multikey();
    int base;
    logic [3:0] seen;
    base = press_cnt;
    seen = 4'h0;
    keys = 16'h0; keys[5] = 1'b1; keys[9] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen = seen | ~col;
    end
    total++; if (seen !== 4'hF) $display("FAIL multi_rotate: got columns %b expected 1111", seen); else passed++;
    total++; if (press_cnt !== base) $display("FAIL multi_no_press: got %0d presses expected 0", press_cnt - base); else passed++;
    total++; if (key_held !== 1'b0) $display("FAIL multi_held: got %b expected 0", key_held); else passed++;
    keys = 16'h0;
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    keys = 16'h0; keys[15] = 1'b1;
    wait_press(100, ok);
    total++; if (!ok || scan_code !== 4'hD) $display("FAIL keyD_press: got code %h seen %b expected D", scan_code, ok); else passed++;
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    total++; if (key_held !== 1'b0) $display("FAIL midrst_held: got %b expected 0", key_held); else passed++;
    total++; if (col !== 4'b1110) $display("FAIL midrst_col: got %b expected 1110", col); else passed++;
    total++; if (scan_code !== 4'h0) $display("FAIL midrst_code: got %h expected 0", scan_code); else passed++;
    keys = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    base = press_cnt;
    repeat (40) @(posedge clk);
    #1;
    total++; if (press_cnt !== base) $display("FAIL midrst_spurious: got %0d presses expected 0", press_cnt - base); else passed++;
  endtask

  task automatic test_back_to_back();
    int pos [10];
    logic [3:0] code [10];
    int base;
    bit ok;
    pos = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 13};
    code = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'h0};
    base = press_cnt;
    for (int i = 0; i < 10; i++) begin
      keys = 16'h0; keys[pos[i]] = 1'b1;
      wait_press(100, ok);
      total++; if (!ok || scan_code !== code[i]) $display("FAIL seq%0d_code: got %h seen %b expected %h", i, scan_code, ok, code[i]); else passed++;
      @(posedge clk); #1;
      total++; if (press !== 1'b0) $display("FAIL seq%0d_width: got %b expected 0", i, press); else passed++;
      keys = 16'h0;
      wait_released(60, ok);
      total++; if (!ok) $display("FAIL seq%0d_release: got key_held %b expected 0", i, key_held); else passed++;
    end
    total++; if (press_cnt - base != 10) $display("FAIL seq_pulses: got %0d expected 10", press_cnt - base); else passed++;
  endtask

  initial begin
    total = 0; passed = 0; press_cnt = 0;
    test_reset();
    test_idle();
    test_key5();
    test_bounce();
    test_multikey();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 1000, clock cycles per scan tick (legal range 4 to 65535).
REQ-002 The module SHALL have parameter DEBOUNCE_CNT, default 4, consecutive stable ticks needed to accept a press or a release (legal range 2 to 255).
REQ-003 Port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port row, input, 4 bits: keypad row lines, active-low, pulled up, asynchronous to clk.
REQ-006 Port col, output, 4 bits: keypad column drive, active-low one-hot.
REQ-007 Port press, output, 1 bit: one-cycle strobe marking a new accepted key.
REQ-008 Port scan_code, output, 4 bits: code of the last accepted key; valid when press=1 and held afterwards.
REQ-009 Port key_held, output, 1 bit: high from the press strobe until the release is accepted.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer (reset value 4'hF); all decisions SHALL use the synchronized value rs.
REQ-011 The tick counter SHALL assert an internal tick for one cycle every SCAN_DIV cycles, free-running in all states.
REQ-012 FSM states SHALL be SCAN, DEBOUNCE, EMIT and WAIT_RELEASE.
REQ-013 In SCAN on tick: if rs has exactly one bit low, capture row index r (bit position) and column index c (col bit low), set the stable count to 1 and go to DEBOUNCE with col frozen; otherwise rotate col 1110->1101->1011->0111->1110 and stay in SCAN.
REQ-014 rs values with zero bits low or two or more bits low SHALL be treated as no key (multi-key rejected).
REQ-015 In DEBOUNCE on tick: if rs equals the captured pattern, increment the count; on reaching DEBOUNCE_CNT go to EMIT; on any mismatch go to SCAN, clear the count and advance col to the next column.
REQ-016 EMIT SHALL last exactly one clock with press=1 and scan_code loaded per REQ-017, then go to WAIT_RELEASE; key_held=1 from the same edge.
REQ-017 Mapping from (r,c), in row order r0..r3 with c0..c3 per row: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E(*),0,F(#),D.
REQ-018 In WAIT_RELEASE col SHALL stay frozen; on tick with rs=4'hF increment the release count, and on tick with any bit low clear it; at DEBOUNCE_CNT clear key_held, clear the count, advance col and go to SCAN.
REQ-019 press SHALL never assert twice for one continuous hold; auto-repeat is not supported.
REQ-020 A bounce (mismatch) before the count completes SHALL produce no press and leave scan_code unchanged.
REQ-021 press latency: press is high in the cycle after the tick on which the count reaches DEBOUNCE_CNT, i.e. (DEBOUNCE_CNT-1)*SCAN_DIV+1 cycles after the detection tick.
REQ-022 Counters SHALL saturate and not wrap; the tick counter SHALL wrap from SCAN_DIV-1 to 0.

Reset
REQ-023 While rst=0: col=4'b1110, press=0, scan_code=4'h0, key_held=0, state=SCAN, all counters 0, synchronizer=4'hF.
REQ-024 Reset asserted mid-DEBOUNCE or mid-WAIT_RELEASE SHALL abort at once with no press; after release of reset, scanning SHALL restart at col=1110.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-025 Idle with row=4'hF: col cycles 1110,1101,1011,0111 every 4 clocks; press is never high.
REQ-026 Key '5' (row1 low while col=1101) held for 40 clocks: exactly one press pulse with scan_code=4'h5, then key_held=1 until 3 released ticks, then SCAN resumes at col=1011.
REQ-027 Key '0' (row3 while col=1101) bounces high at the 2nd tick: no press, scan_code unchanged; a held retry gives press with scan_code=4'h0.
REQ-028 row1 and row2 low together: no press, col keeps rotating.
REQ-029 rst pulsed low during WAIT_RELEASE of key 'D': key_held=0, col=1110 immediately, no spurious press.
REQ-030 Ten keys 1,2,...,9,0 in sequence: ten press pulses with codes 1..9,0, each exactly one cycle wide.
